// File: rtl/viola_pkg.sv
// viola_pkg: shared register-file writeback widths and request type.
package viola_pkg;
   localparam int REG_ADDR_W = 5;
   localparam int DATA_W     = 32;
   localparam int TAG_W      = 3;
   localparam logic [TAG_W-1:0] TAG_NONE = '0;
   typedef struct packed {
      logic [REG_ADDR_W-1:0] rd;
      logic [DATA_W-1:0]     data;
      logic [TAG_W-1:0]      tag;
   } wb_req_t;
endpackage

// File: rtl/rr_picker.sv
// rr_picker: one-hot grant of the first set request bit, searching upward from i_ptr+1 mod N.
module rr_picker #(
   parameter int N  = 3,
   parameter int PW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  i_req,
   input  logic [PW-1:0] i_ptr,
   output logic [N-1:0]  o_gnt,
   output logic [PW-1:0] o_idx
);
   always_comb begin
      o_gnt = '0;
      o_idx = '0;
      // descending scan so the nearest candidate after i_ptr is written last
      for (int k = N; k >= 1; k--) begin
         int j;
         j = (int'(i_ptr) + k) % N;
         if (i_req[j]) begin
            o_gnt    = '0;
            o_gnt[j] = 1'b1;
            o_idx    = PW'(j);
         end
      end
   end
endmodule

// File: rtl/rf_commit_arbiter.sv
// rf_commit_arbiter: arbitrates writeback requesters onto the single register-file commit slot.
// Define RF_ARB_ROUND_ROBIN_EN for rotating priority; otherwise lowest index wins.
module rf_commit_arbiter #(
   parameter int NREQ   = 3,
   parameter int DATA_W = viola_pkg::DATA_W,
   parameter int TAG_W  = viola_pkg::TAG_W
) (
   input  logic                                  i_clk,
   input  logic                                  i_rst_n,
   input  logic                                  i_pause,
   input  logic                                  i_flush,
   input  logic [NREQ-1:0]                       i_req_valid,
   output logic [NREQ-1:0]                       o_req_ready,
   input  logic [NREQ*viola_pkg::REG_ADDR_W-1:0] i_req_rd,
   input  logic [NREQ*DATA_W-1:0]                i_req_data,
   input  logic [NREQ*TAG_W-1:0]                 i_req_tag,
   output logic                                  o_commit,
   output logic [viola_pkg::REG_ADDR_W-1:0]      o_reg_num,
   output logic [DATA_W-1:0]                     o_data_in,
   output logic [TAG_W-1:0]                      o_num_in,
   output logic                                  o_busy
);
   localparam int RW = viola_pkg::REG_ADDR_W;
   localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
   logic              r_commit;
   logic [RW-1:0]     r_reg;
   logic [DATA_W-1:0] r_data;
   logic [TAG_W-1:0]  r_tag;
   logic              w_free;
   logic [NREQ-1:0]   w_req;
   logic [NREQ-1:0]   w_gnt;
   logic [PW-1:0]     w_idx;
   logic [PW-1:0]     w_ptr;
   logic              w_xfer;
   // reset gates the grant so req_ready is zero while rst_n is low
   assign w_free = !r_commit || !i_pause;
   assign w_req  = (i_rst_n && w_free && !i_flush) ? i_req_valid : '0;
   assign w_xfer = |w_gnt;
`ifdef RF_ARB_ROUND_ROBIN_EN
   logic [PW-1:0] r_ptr;
   assign w_ptr = r_ptr;
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) r_ptr <= PW'(NREQ - 1);
      else if (!i_flush && w_xfer) r_ptr <= w_idx;
   end
`else
   assign w_ptr = PW'(NREQ - 1);
`endif
   rr_picker #(.N(NREQ), .PW(PW)) u_pick (
      .i_req (w_req),
      .i_ptr (w_ptr),
      .o_gnt (w_gnt),
      .o_idx (w_idx)
   );
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_commit <= 1'b0;
         r_reg    <= '0;
         r_data   <= '0;
         r_tag    <= '0;
      end else if (i_flush) begin
         r_commit <= 1'b0;
      end else if (w_xfer) begin
         r_commit <= 1'b1;
         r_reg    <= i_req_rd[w_idx*RW +: RW];
         r_data   <= i_req_data[w_idx*DATA_W +: DATA_W];
         r_tag    <= i_req_tag[w_idx*TAG_W +: TAG_W];
      end else if (!i_pause) begin
         r_commit <= 1'b0;
      end
   end
   assign o_req_ready = w_gnt;
   assign o_commit    = r_commit;
   assign o_reg_num   = r_reg;
   assign o_data_in   = r_data;
   assign o_num_in    = r_tag;
   assign o_busy      = r_commit | (|i_req_valid);
endmodule

// File: doc/rf_commit_arbiter.md
# rf_commit_arbiter

Round-robin arbiter that shares the register file's single commit port (`commit`, `reg_num`, `data_in`, `num_in`) among several writeback requesters (ALU, LSU, branch unit). It accepts one writeback per cycle through valid/ready handshakes and holds it in a one-entry output slot. The slot drives the register file and stays stable while `pause` is high. The block sits between the execution units and the register file and is the only driver of the commit port.

## Interface
- `NREQ`, 3: number of writeback requesters (2..8).
- `DATA_W`, 32: register data width.
- `TAG_W`, 3: dependency-tag width; tag 0 means "no dependency".
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst`  in  1  reset, asynchronous, active-low; low clears all state.
- `pause`  in  1  global stall; the register file ignores commit while it is high.
- `flush`  in  1  synchronous discard of the output slot; blocks acceptance this cycle.
- `req_valid`  in  NREQ  requester i has a writeback.
- `req_ready`  out  NREQ  one-hot-or-zero grant; a transfer occurs when valid&ready are high at a rising edge.
- `req_rd`  in  NREQ*5  destination register, requester i in bits [5i+4:5i].
- `req_data`  in  NREQ*DATA_W  writeback value.
- `req_tag`  in  NREQ*TAG_W  dependency tag of the producing instruction.
- `commit`  out  1  output slot valid; drives the register-file commit input.
- `reg_num`  out  5  register written.
- `data_in`  out  DATA_W  value written.
- `num_in`  out  TAG_W  tag compared against the register's dependency entry.
- `busy`  out  1  `commit` | (|`req_valid`).

## Operation
- Output slot: registers `commit_q`, `reg_q`, `data_q`, `tag_q` drive `commit`, `reg_num`, `data_in` and `num_in` directly.
- The slot is free this cycle when `!commit_q || !pause`. A held slot is consumed at the next edge when `pause` is low.
- Grant is combinational. When the slot is free, `flush` is low and any `req_valid` is high, exactly one `req_ready` bit is high. It selects the first valid requester searching from `ptr+1` mod NREQ upward. Otherwise `req_ready` is all zero.
- `req_ready[i]` may depend on `req_valid[i]`. Requesters must not make `req_valid` depend on `req_ready`.
- On a transfer from requester g:
  - The slot loads g's rd, data and tag, and `commit_q` is set to 1.
  - `ptr` is set to g.
- The slot clears to `commit_q`=0 when it is consumed with no new transfer, or when `flush` is high. `flush` wins over every other event.
- While paused with the slot full, all fields hold bit-stable and `ptr` holds.
- Requests with rd=0 are accepted and committed unchanged; the register file handles x0.
- Tag 0 passes through unchanged.
- Order from one requester is preserved. No ordering is guaranteed between requesters. Same-rd races are resolved by the register file's tag compare.
- Reset values: `commit`=0, `reg_num`=0, `data_in`=0, `num_in`=0, `req_ready`=0, `ptr`=NREQ-1 (so requester 0 has first priority), `busy` follows its inputs.

## Timing
- Latency: request accepted at edge N, `commit` high from N to N+1, and the register file writes at edge N+1 if `pause` is low.
- Throughput: one commit per cycle when unpaused. A consume and a new load happen at the same edge with no bubble.
- Pause mid-transfer: ready is already low when the slot is full, so no request is lost.
- Pause with the slot empty: one request may still be accepted, and it is then held.
- Asynchronous reset mid-operation: the slot is dropped immediately and no partial commit is issued after release.
- Reset deassertion is expected to be synchronised externally.

## Configuration
- `RF_ARB_ROUND_ROBIN_EN` defined: rotating priority as described, with `ptr` updated on each transfer.
- `RF_ARB_ROUND_ROBIN_EN` undefined: fixed priority, lowest index wins. `ptr` is removed and all other behaviour is identical.

## Structure
- Shared package `viola_pkg`: `REG_ADDR_W`=5, `DATA_W`=32, `TAG_W`=3, `TAG_NONE`=0, and a `wb_req_t` struct (rd, data, tag).
- Sub-module `rr_picker`: combinational, inputs `NREQ` request bits and the start pointer, outputs a one-hot grant and its index. It is instantiated once. In the fixed-priority build the start pointer is tied to NREQ-1.

## Test plan
- Single request, no pause: req0 {rd=5, data=0xDEADBEEF, tag=2} accepted at edge 1 → `commit`=1 with reg 5, 0xDEADBEEF, tag 2 for exactly one cycle.
- All three valid continuously for 6 cycles (round-robin build) → grant order 0,1,2,0,1,2 and `commit` high every cycle. Fixed-priority build → 0,0,0,… (requester 0 always wins).
- Slot full, `pause` high for 4 cycles → outputs stable, `req_ready`=0. When pause falls, the held entry is consumed and the next request loads on the same edge.
- `flush` with slot full and req1 valid → at the next edge `commit`=0 and req1 is not accepted (`req_ready`=0 that cycle).
- `rst` asserted low asynchronously mid-stream → `commit` and `req_ready` go to 0 without waiting for a clock. After release, first grant goes to requester 0.
- Request with rd=0, tag=0 → committed unchanged as reg 0, tag 0.
